// File: rtl/seg_pkg.sv
// seg_pkg
// Shared definitions for the seven-segment scan controller slice.
//   DIGIT_W     : width of one digit code (BCD nibble)
//   BLANK_CODE  : code the external decoder renders as an unlit digit
//   scanState_t : scan FSM state, BLANK (all enables off) or SHOW
// Optional feature macro used by seg_scan_ctrl: SEG_SCAN_LEADING_ZERO_BLANK_EN
package seg_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scanState_t;

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer
// Slot prescaler for the display scan. Counts 0..TICK_DIV-1 and reports
// where the count sits within the slot.
// Parameters:
//   TICK_DIV     : clock cycles per digit slot
//   BLANK_CYCLES : cycles of blanking at the start of each slot (0 legal)
// Ports:
//   i_clk          in  clock, rising edge
//   i_reset        in  synchronous active-high reset
//   o_slotEnd      out high on the last cycle of a slot (count == TICK_DIV-1)
//   o_blankEnd     out high on the last blanking cycle (count == BLANK_CYCLES-1)
//   o_nextSlotEnd  out high when the following cycle will be a slot end
// Related feature macro (not used here): SEG_SCAN_LEADING_ZERO_BLANK_EN
module seg_scan_timer #(
  parameter int TICK_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_slotEnd,
  output logic o_blankEnd,
  output logic o_nextSlotEnd
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_nextCount;

  // Decode the strobes from the current count. The look-ahead strobe lets
  // the controller register frame_done so it lines up with the boundary
  // cycle instead of trailing it by one.
  always_comb begin
    o_slotEnd     = (r_count == CNT_W'(TICK_DIV - 1));
    o_blankEnd    = (BLANK_CYCLES != 0) && (r_count == CNT_W'(BLANK_CYCLES - 1));
    w_nextCount   = o_slotEnd ? '0 : r_count + CNT_W'(1);
    o_nextSlotEnd = (w_nextCount == CNT_W'(TICK_DIV - 1));
  end

  // Free-running prescaler, wrapping at the end of every slot so that
  // every slot is exactly TICK_DIV cycles long.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_nextCount;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexing scan controller for a common-cathode seven-segment
// display. Holds a double-buffered frame of digit codes, presents one code
// per slot to the shared external decoder and drives the matching one-hot
// digit enable, with a blanking gap at the start of each slot.
// Parameters:
//   DIGITS       : number of digits (2..8)
//   TICK_DIV     : cycles per digit slot (>= BLANK_CYCLES+1)
//   BLANK_CYCLES : blanking cycles at the start of each slot (0 legal)
// Ports:
//   clk         in  clock, rising edge
//   reset       in  synchronous active-high reset
//   load        in  frame load request
//   load_data   in  new frame, nibble k is digit k (digit 0 least significant)
//   load_ready  out pending buffer empty; load accepted when load && load_ready
//   digit_code  out code of the digit being scanned
//   digit_en    out one-hot digit enable, zero while blanking
//   frame_done  out one-cycle pulse on the last cycle of the last digit slot
// Feature macro: SEG_SCAN_LEADING_ZERO_BLANK_EN keeps leading-zero digits
// (above digit 0) dark during their SHOW phase.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int TICK_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [DIGIT_W*DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [DIGIT_W-1:0]      digit_code,
  output logic [DIGITS-1:0]       digit_en,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  scanState_t r_state;
  scanState_t w_nextState;

  logic [IDX_W-1:0]          r_index;
  logic [IDX_W-1:0]          w_nextIndex;
  logic [DIGIT_W*DIGITS-1:0] r_active;
  logic [DIGIT_W*DIGITS-1:0] r_pending;
  logic                      r_pendingValid;
  logic [DIGIT_W*DIGITS-1:0] w_nextActive;
  logic                      w_nextPendingValid;
  logic                      w_transfer;
  logic                      w_accept;
  logic                      w_lastSlot;

  logic                      r_loadReady;
  logic [DIGIT_W-1:0]        r_code;
  logic [DIGITS-1:0]         r_en;
  logic                      r_frameDone;
  logic [DIGIT_W-1:0]        w_nextCode;
  logic [DIGITS-1:0]         w_nextEn;
  logic                      w_nextFrameDone;

  logic                      w_slotEnd;
  logic                      w_blankEnd;
  logic                      w_nextSlotEnd;

  seg_scan_timer #(
    .TICK_DIV    (TICK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .i_clk        (clk),
    .i_reset      (reset),
    .o_slotEnd    (w_slotEnd),
    .o_blankEnd   (w_blankEnd),
    .o_nextSlotEnd(w_nextSlotEnd)
  );

  // Next-state logic for the scan FSM, the digit index and the frame
  // buffers. Every output is registered, so the output values for the next
  // cycle are computed here from the next index/state/frame; that way
  // digit_en, digit_code and frame_done change on the same edge as the
  // state they describe. The frame transfer only happens on the boundary
  // edge and uses the pending flag as it was before that edge, so a load
  // accepted on the boundary cycle waits for the following boundary.
  always_comb begin
    w_nextState        = r_state;
    w_nextIndex        = r_index;
    w_lastSlot         = (r_index == LAST_IDX);
    w_transfer         = w_slotEnd && w_lastSlot && r_pendingValid;
    w_accept           = load && !r_pendingValid;
    w_nextActive       = r_active;
    w_nextPendingValid = r_pendingValid;
    w_nextEn           = '0;
    w_nextCode         = '0;
    w_nextFrameDone    = 1'b0;

    if (w_slotEnd) begin
      w_nextIndex = w_lastSlot ? '0 : r_index + IDX_W'(1);
    end

    case (r_state)
      BLANK: begin
        if (w_slotEnd) begin
          w_nextState = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end else if ((BLANK_CYCLES == 0) || w_blankEnd) begin
          w_nextState = SHOW;
        end
      end
      SHOW: begin
        if (w_slotEnd) begin
          w_nextState = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end
      end
    endcase

    if (w_transfer) begin
      w_nextActive       = r_pending;
      w_nextPendingValid = 1'b0;
    end else if (w_accept) begin
      w_nextPendingValid = 1'b1;
    end

    if (w_nextState == SHOW) begin
      w_nextEn = DIGITS'(1) << w_nextIndex;
    end
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    if ((w_nextIndex != '0) && ((w_nextActive >> (w_nextIndex * DIGIT_W)) == '0)) begin
      w_nextEn = '0;
    end
`endif

    w_nextCode      = w_nextActive[w_nextIndex*DIGIT_W +: DIGIT_W];
    w_nextFrameDone = (w_nextIndex == LAST_IDX) && w_nextSlotEnd;
  end

  // Scan FSM state and digit index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BLANK;
      r_index <= '0;
    end else begin
      r_state <= w_nextState;
      r_index <= w_nextIndex;
    end
  end

  // Double-buffered frame storage. Pending data is only written while the
  // pending buffer is empty, so an unconsumed frame is never overwritten;
  // reset discards both the shown and the pending frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active       <= '0;
      r_pending      <= '0;
      r_pendingValid <= 1'b0;
    end else begin
      r_active       <= w_nextActive;
      r_pendingValid <= w_nextPendingValid;
      if (w_accept) begin
        r_pending <= load_data;
      end
    end
  end

  // Output registers, loaded with the look-ahead values so that the pins
  // always reflect the current index, state and active frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_loadReady <= 1'b1;
      r_code      <= '0;
      r_en        <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_loadReady <= !w_nextPendingValid;
      r_code      <= w_nextCode;
      r_en        <= w_nextEn;
      r_frameDone <= w_nextFrameDone;
    end
  end

  assign load_ready = r_loadReady;
  assign digit_code = r_code;
  assign digit_en   = r_en;
  assign frame_done = r_frameDone;

endmodule
